// File: rtl/iom_bus_slave.sv
// rtl/iom_bus_slave.sv - 8088 minimum-mode IOM bus slave with decoded window, wait states and byte RAM
// Optional write protection (WP/WP_HIT ports) is enabled by defining IOM_WRITE_PROTECT_EN.
module iom_bus_slave #(
  parameter logic [19:0] BASE_ADDR   = 20'h00000,
  parameter int          DEPTH       = 256,
  parameter int          IO_SPACE    = 0,
  parameter int          WAIT_STATES = 0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ALE,
  input  logic        IOM,
  input  logic        RD,
  input  logic        WR,
  input  logic [11:0] A,
  input  logic [7:0]  AD_IN,
  output logic [7:0]  AD_OUT,
  output logic        AD_OE,
  output logic        READY
`ifdef IOM_WRITE_PROTECT_EN
  ,
  input  logic        WP,
  output logic        WP_HIT
`endif
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [3:0]  WS       = 4'(WAIT_STATES);
  localparam logic [19:0] MASK_MEM = ~(20'(DEPTH - 1));
  // I/O space only decodes the low 16 address bits
  localparam logic [19:0] MASK     = (IO_SPACE != 0) ? (MASK_MEM & 20'h0FFFF) : MASK_MEM;

  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_WAIT, S_XFER, S_DONE} state_t;

  state_t        r_state;
  logic [19:0]   r_addr;
  logic          r_io;
  logic [3:0]    r_cnt;
  logic          r_rd;
  logic [7:0]    r_mem [DEPTH];

  logic          w_sel;
  logic          w_rd_lo;
  logic          w_wr_lo;
  logic          w_both;
  logic          w_strobe_on;
  logic          w_commit;
  logic          w_block;
  logic          w_we;
  logic [AW-1:0] w_off;

  assign w_rd_lo     = !RD;
  assign w_wr_lo     = !WR;
  assign w_both      = w_rd_lo && w_wr_lo;
  assign w_sel       = (r_io == (IO_SPACE != 0)) && (((r_addr ^ BASE_ADDR) & MASK) == 20'h0);
  assign w_off       = r_addr[AW-1:0];
  assign w_strobe_on = r_rd ? w_rd_lo : w_wr_lo;

  // Write lands on the WAIT->XFER edge; mirrors the FSM's WAIT branch priority exactly
  assign w_commit = (r_state == S_WAIT) && !ALE && !w_both && w_strobe_on &&
                    (r_cnt == 4'd0) && !r_rd;

`ifdef IOM_WRITE_PROTECT_EN
  assign w_block = WP;
`else
  assign w_block = 1'b0;
`endif

  assign w_we  = w_commit && !w_block;
  assign READY = !((r_state == S_WAIT) && (r_cnt != 4'd0));

  always_ff @(posedge CLK) begin
    if (w_we) r_mem[w_off] <= AD_IN;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= S_IDLE;
      r_addr  <= 20'h0;
      r_io    <= 1'b0;
      r_cnt   <= 4'd0;
      r_rd    <= 1'b0;
      AD_OUT  <= 8'h00;
      AD_OE   <= 1'b0;
`ifdef IOM_WRITE_PROTECT_EN
      WP_HIT  <= 1'b0;
`endif
    end else begin
`ifdef IOM_WRITE_PROTECT_EN
      WP_HIT <= 1'b0;
`endif
      if (ALE) begin
        // A new address phase always wins, aborting whatever cycle was in flight
        r_addr  <= {A, AD_IN};
        r_io    <= IOM;
        r_cnt   <= 4'd0;
        AD_OE   <= 1'b0;
        r_state <= S_LATCH;
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_IDLE;
          S_LATCH: begin
            if (!w_sel) begin
              r_state <= S_IDLE;
            end else if (w_both) begin
              r_state <= S_DONE;
            end else if (w_rd_lo || w_wr_lo) begin
              r_rd    <= w_rd_lo;
              r_cnt   <= WS;
              r_state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (w_both) begin
              r_cnt   <= 4'd0;
              r_state <= S_DONE;
            end else if (!w_strobe_on) begin
              r_cnt   <= 4'd0;
              r_state <= S_IDLE;
            end else if (r_cnt != 4'd0) begin
              r_cnt <= r_cnt - 4'd1;
            end else begin
              r_state <= S_XFER;
`ifdef IOM_WRITE_PROTECT_EN
              WP_HIT <= !r_rd && WP;
`endif
            end
          end
          S_XFER: begin
            if (r_rd) begin
              AD_OUT <= r_mem[w_off];
              AD_OE  <= 1'b1;
            end
            r_state <= S_DONE;
          end
          S_DONE: begin
            if (RD && WR) begin
              AD_OE   <= 1'b0;
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iom_bus_slave.sv
// tb/tb_iom_bus_slave.sv - scoreboard bench: memory slave (3 waits) and I/O slave (0 waits) on one bus
// Write-protect checks are compiled in when IOM_WRITE_PROTECT_EN is defined.
module tb_iom_bus_slave;

  logic        clk;
  logic        rst_n;
  logic        ale;
  logic        iom;
  logic        rd_n;
  logic        wr_n;
  logic [11:0] a_hi;
  logic [7:0]  ad_in;
  logic        wp;
  logic [7:0]  ad_out_m, ad_out_i;
  logic        ad_oe_m, ad_oe_i;
  logic        ready_m, ready_i;
  logic        wp_hit_m, wp_hit_i;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    logic [7:0] data;
    int         who;
  } exp_t;
  exp_t sb_q[$];

  iom_bus_slave #(.BASE_ADDR(20'h08000), .DEPTH(256), .IO_SPACE(0), .WAIT_STATES(3)) u_m (
    .CLK(clk), .RESET(rst_n), .ALE(ale), .IOM(iom), .RD(rd_n), .WR(wr_n), .A(a_hi),
    .AD_IN(ad_in), .AD_OUT(ad_out_m), .AD_OE(ad_oe_m), .READY(ready_m)
`ifdef IOM_WRITE_PROTECT_EN
    , .WP(wp), .WP_HIT(wp_hit_m)
`endif
  );

  iom_bus_slave #(.BASE_ADDR(20'h08000), .DEPTH(256), .IO_SPACE(1), .WAIT_STATES(0)) u_i (
    .CLK(clk), .RESET(rst_n), .ALE(ale), .IOM(iom), .RD(rd_n), .WR(wr_n), .A(a_hi),
    .AD_IN(ad_in), .AD_OUT(ad_out_i), .AD_OE(ad_oe_i), .READY(ready_i)
`ifdef IOM_WRITE_PROTECT_EN
    , .WP(wp), .WP_HIT(wp_hit_i)
`endif
  );

`ifndef IOM_WRITE_PROTECT_EN
  assign wp_hit_m = 1'b0;
  assign wp_hit_i = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every rising AD_OE pops one expected read
  logic p_oe_m = 1'b0;
  logic p_oe_i = 1'b0;
  int   n_hit  = 0;

  task automatic sb_pop(input int who, input logic [7:0] data);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_spurious_oe", 32'(who), 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk("sb_who", 32'(who), 32'(e.who));
      chk("sb_data", 32'(data), 32'(e.data));
    end
  endtask

  always @(negedge clk) begin
    if (ad_oe_m && !p_oe_m) sb_pop(1, ad_out_m);
    if (ad_oe_i && !p_oe_i) sb_pop(2, ad_out_i);
    if (wp_hit_m || wp_hit_i) n_hit++;
    p_oe_m = ad_oe_m;
    p_oe_i = ad_oe_i;
  end

  task automatic idle(input int n);
    rd_n = 1'b1;
    wr_n = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic t_addr(input logic io, input logic [19:0] addr);
    @(negedge clk);
    ale   = 1'b1;
    iom   = io;
    a_hi  = addr[19:8];
    ad_in = addr[7:0];
    @(negedge clk);
    ale = 1'b0;
  endtask

  // who: 0 = nobody selected, 1 = memory slave, 2 = I/O slave
  task automatic bus_rd(input string tag, input logic io, input logic [19:0] addr,
                        input logic [7:0] exp, input int who);
    int k = 0;
    int lows = 0;
    logic seen = 1'b0;
    t_addr(io, addr);
    rd_n = 1'b0;
    if (who != 0) sb_q.push_back('{data: exp, who: who});
    @(posedge clk);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!ready_m || !ready_i) lows++;
      if (ad_oe_m || ad_oe_i) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      k++;
    end
    if (who != 0) begin
      chk({tag, "_oe_seen"}, 32'(seen), 32'd1);
      chk({tag, "_latency"}, 32'(k), (who == 1) ? 32'd5 : 32'd2);
      chk({tag, "_ready_low"}, 32'(lows), (who == 1) ? 32'd3 : 32'd0);
    end else begin
      chk({tag, "_no_oe"}, 32'(seen), 32'd0);
      chk({tag, "_no_ready_low"}, 32'(lows), 32'd0);
    end
    idle(2);
  endtask

  task automatic bus_wr(input string tag, input logic io, input logic [19:0] addr,
                        input logic [7:0] data, input int exp_lows, input logic both);
    int lows = 0;
    logic seen = 1'b0;
    t_addr(io, addr);
    wr_n  = 1'b0;
    ad_in = data;
    if (both) rd_n = 1'b0;
    @(posedge clk);
    repeat (10) begin
      @(negedge clk);
      if (!ready_m || !ready_i) lows++;
      if (ad_oe_m || ad_oe_i) seen = 1'b1;
    end
    chk({tag, "_ready_low"}, 32'(lows), 32'(exp_lows));
    chk({tag, "_no_oe"}, 32'(seen), 32'd0);
    idle(2);
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; ale = 1'b0; iom = 1'b0; rd_n = 1'b1; wr_n = 1'b1;
    a_hi = 12'h0; ad_in = 8'h0; wp = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_oe_m", 32'(ad_oe_m), 32'd0);
    chk("rst_ready_m", 32'(ready_m), 32'd1);
    chk("rst_out_m", 32'(ad_out_m), 32'd0);
    chk("rst_oe_i", 32'(ad_oe_i), 32'd0);
    chk("rst_ready_i", 32'(ready_i), 32'd1);
    rst_n = 1'b1;
    idle(2);

    // Window top and base, then the just-outside neighbours must alias nothing
    bus_wr("wr_top", 1'b0, 20'h080FF, 8'hA5, 3, 1'b0);
    bus_rd("rd_top", 1'b0, 20'h080FF, 8'hA5, 1);
    bus_wr("wr_base", 1'b0, 20'h08000, 8'h11, 3, 1'b0);
    bus_rd("rd_base", 1'b0, 20'h08000, 8'h11, 1);
    bus_wr("wr_below", 1'b0, 20'h07FFF, 8'hEE, 0, 1'b0);
    bus_wr("wr_above", 1'b0, 20'h08100, 8'hEE, 0, 1'b0);
    bus_rd("rd_below", 1'b0, 20'h07FFF, 8'h00, 0);
    bus_rd("rd_above", 1'b0, 20'h08100, 8'h00, 0);
    bus_rd("rd_top2", 1'b0, 20'h080FF, 8'hA5, 1);
    bus_rd("rd_base2", 1'b0, 20'h08000, 8'h11, 1);

    // Memory and I/O spaces at the same address stay separate
    bus_wr("wr_mem10", 1'b0, 20'h08010, 8'h5A, 3, 1'b0);
    bus_wr("wr_io10", 1'b1, 20'h08010, 8'h3C, 0, 1'b0);
    bus_rd("rd_io10", 1'b1, 20'h08010, 8'h3C, 2);
    bus_rd("rd_mem10", 1'b0, 20'h08010, 8'h5A, 1);
    bus_rd("rd_io_hi", 1'b1, 20'hF8010, 8'h3C, 2);
    bus_rd("rd_io_miss", 1'b1, 20'h08110, 8'h00, 0);

    // Bus error: both strobes low writes nothing
    bus_wr("wr_22", 1'b0, 20'h08020, 8'h22, 3, 1'b0);
    bus_wr("wr_both", 1'b0, 20'h08020, 8'h77, 0, 1'b1);
    bus_rd("rd_after_both", 1'b0, 20'h08020, 8'h22, 1);

    // Strobe released during wait states
    t_addr(1'b0, 20'h08020);
    wr_n = 1'b0; ad_in = 8'h99;
    @(posedge clk);
    @(negedge clk);
    chk("rel_wait_ready", 32'(ready_m), 32'd0);
    wr_n = 1'b1;
    @(negedge clk);
    chk("rel_ready_back", 32'(ready_m), 32'd1);
    idle(2);
    bus_rd("rd_after_rel", 1'b0, 20'h08020, 8'h22, 1);

    // ALE during wait states aborts and re-latches an unselected address
    t_addr(1'b0, 20'h08020);
    wr_n = 1'b0; ad_in = 8'h66;
    @(posedge clk);
    @(negedge clk);
    wr_n = 1'b1; ale = 1'b1; a_hi = 12'h070; ad_in = 8'h00;
    @(negedge clk);
    chk("ale_abort_ready", 32'(ready_m), 32'd1);
    ale = 1'b0;
    idle(3);
    bus_rd("rd_after_ale", 1'b0, 20'h08020, 8'h22, 1);

    // Reset asserted mid-write before the transfer
    t_addr(1'b0, 20'h08020);
    wr_n = 1'b0; ad_in = 8'h44;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    bus_rd("rd_after_rst", 1'b0, 20'h08020, 8'h22, 1);

`ifdef IOM_WRITE_PROTECT_EN
    bus_wr("wr_12", 1'b0, 20'h08040, 8'h12, 3, 1'b0);
    wp = 1'b1;
    n_hit = 0;
    bus_wr("wr_wp", 1'b0, 20'h08040, 8'hFF, 3, 1'b0);
    wp = 1'b0;
    chk("wp_hit_pulses", 32'(n_hit), 32'd1);
    bus_rd("rd_wp", 1'b0, 20'h08040, 8'h12, 1);
`endif

    // Async reset while a read is being driven in DONE
    begin
      logic seen = 1'b0;
      t_addr(1'b0, 20'h080FF);
      rd_n = 1'b0;
      sb_q.push_back('{data: 8'hA5, who: 1});
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (ad_oe_m) begin
          seen = 1'b1;
          break;
        end
      end
      chk("t1_oe_seen", 32'(seen), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t1_rst_oe", 32'(ad_oe_m), 32'd0);
      chk("t1_rst_ready", 32'(ready_m), 32'd1);
      chk("t1_rst_out", 32'(ad_out_m), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);
    end

    chk("sb_left", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
